dmem_access_unit: RTL
=====================

// Module: dmem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit of the pipelined RV32I core. It sits between EX/MEM and MEM/WB.
//  It issues one load/store per instruction to the data cache through a req/resp handshake and
//  stalls the pipeline until the response arrives.
//  It produces mdr_out (raw aligned word) and mem_byte_enable_out; writeback uses both to extract and extend lb/lbu/lh/lhu.
// PARAMETERS
//  ADDR_W   32  byte address width
//  DATA_W   32  data width; fixed at 32, byte-enable width is DATA_W/8 = 4
// PORTS
//  clk                  in   1   clock
//  rst                  in   1   asynchronous reset, active high
//  in_valid             in   1   EX/MEM holds a valid instruction
//  in_load              in   1   instruction is a load
//  in_store             in   1   instruction is a store; wins if in_load also set
//  in_funct3            in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
//  in_addr              in   32  byte address (ALU result)
//  in_wdata             in   32  rs2 store data, unshifted
//  stall_o              out  1   freeze all upstream stages and hold inputs
//  dmem_read            out  1   cache read request
//  dmem_write           out  1   cache write request
//  dmem_addr            out  32  {in_addr[31:2],2'b00}
//  dmem_wdata           out  32  store data shifted into lane position
//  dmem_byte_enable     out  4   write lane mask; 4'b1111 on reads
//  dmem_rdata           in   32  cache read data, valid with dmem_resp
//  dmem_resp            in   1   one-cycle completion pulse
//  mdr_out              out  32  captured read word (stores: unchanged)
//  mem_byte_enable_out  out  4   lane mask of the completed access
//  out_valid            out  1   one-cycle pulse: access complete, outputs valid
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0; mdr_out=0; mem_byte_enable_out=0.
//  Reset mid-access aborts the request immediately. The cache must tolerate an abandoned request.
//  Lane mask: b/bu -> 4'b0001<<addr[1:0]; h/hu -> 4'b0011<<{addr[1],1'b0}; w -> 4'b1111.
//  Reserved funct3 values are treated as w.
//  Store data: sb -> wdata[7:0] placed at lane addr[1:0]; sh -> wdata[15:0] placed at lane pair addr[1]; sw unshifted.
//  Unselected lanes of dmem_wdata are 0.
//  FSM states: IDLE, ACCESS, DONE.
//   IDLE, no memory op (in_valid=0, or in_load=in_store=0):
//    - stall_o=0, no request, out_valid=0.
//   IDLE, memory op present:
//    - stall_o=1 combinationally.
//    - Capture addr, mask, shifted data and is_store into internal regs.
//    - Next state ACCESS.
//   ACCESS:
//    - dmem_read or dmem_write held at 1 (registered); address, data and mask held stable.
//    - stall_o=1.
//    - On dmem_resp: drop the request the next cycle and go to DONE.
//    - On a load, also load mdr_out<=dmem_rdata.
//    - Load mem_byte_enable_out<=mask.
//   DONE:
//    - out_valid=1 and stall_o=0, so the pipeline advances this edge.
//    - Unconditionally return to IDLE.
//    - The next instruction is evaluated in IDLE; back-to-back memory ops therefore cost one bubble.
//  Latency: request asserted 1 cycle after acceptance; out_valid 1 cycle after dmem_resp.
//   Minimum is 3 cycles with a same-cycle-next response.
//  dmem_resp seen in IDLE or DONE is ignored.
//  dmem_resp arriving on the first ACCESS cycle is legal.
//  The request never deasserts before dmem_resp.
//  mdr_out and mem_byte_enable_out hold until the next completion.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - Misaligned accesses are h/hu with addr[0]=1, or w with addr[1:0]!=0.
//   - A misaligned access issues no request and stays in IDLE.
//   - It gives stall_o=0 and out_valid=0, and adds port misalign_o (out,1).
//   - misalign_o pulses for the one cycle the access is presented.
//  MISALIGN_TRAP_EN undefined:
//   - There is no misalign_o port.
//   - The low address bits are ignored per the mask rules above; misaligned accesses proceed.
// TESTING
//  - lw addr 0x100, resp after 2 cycles, rdata 0xDEADBEEF
//    -> dmem_read high 2 cycles, dmem_addr 0x100, mdr_out 0xDEADBEEF, out_valid 1 cycle, mask 4'b1111.
//  - sb addr 0x203, wdata 0x000000A5
//    -> dmem_write, dmem_addr 0x200, byte_enable 4'b1000, dmem_wdata 0xA5000000.
//  - sh addr 0x302, wdata 0x1234
//    -> byte_enable 4'b1100, dmem_wdata 0x12340000.
//    - lh at the same address -> mem_byte_enable_out 4'b1100.
//  - Non-memory instruction with in_valid=1 -> stall_o 0, no request.
//    - Stray dmem_resp in IDLE -> no state change, mdr_out unchanged.
//  - rst asserted during ACCESS -> dmem_read/dmem_write, stall_o and out_valid drop asynchronously, state IDLE.
//  - MISALIGN_TRAP_EN: lw addr 0x101 -> misalign_o pulse, no request, stall_o 0.
//    - Without the macro -> normal access at dmem_addr 0x100.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: EX/MEM pipeline inputs and data-cache req/resp bus of the MEM-stage access unit.
// misalign_o exists only when MISALIGN_TRAP_EN is defined.
interface dmem_access_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic                in_valid;
    logic                in_load;
    logic                in_store;
    logic [2:0]          in_funct3;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_wdata;
    logic                stall_o;
    logic                dmem_read;
    logic                dmem_write;
    logic [ADDR_W-1:0]   dmem_addr;
    logic [DATA_W-1:0]   dmem_wdata;
    logic [DATA_W/8-1:0] dmem_byte_enable;
    logic [DATA_W-1:0]   dmem_rdata;
    logic                dmem_resp;
    logic [DATA_W-1:0]   mdr_out;
    logic [DATA_W/8-1:0] mem_byte_enable_out;
    logic                out_valid;
`ifdef MISALIGN_TRAP_EN
    logic                misalign_o;
`endif
    modport slave (
`ifdef MISALIGN_TRAP_EN
        output misalign_o,
`endif
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, dmem_rdata, dmem_resp,
        output stall_o, dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
        output mdr_out, mem_byte_enable_out, out_valid
    );
    modport master (
`ifdef MISALIGN_TRAP_EN
        input  misalign_o,
`endif
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, dmem_rdata, dmem_resp,
        input  stall_o, dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
        input  mdr_out, mem_byte_enable_out, out_valid
    );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store unit, one cache req/resp per instruction, stalls until done.
// Define MISALIGN_TRAP_EN to trap misaligned h/w accesses on misalign_o instead of issuing them.
module dmem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    dmem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mdr_q;
    logic [3:0]          mask_q;
    logic [3:0]          be_q;
    logic [3:0]          mbe_q;
    logic                read_q;
    logic                write_q;
    logic                valid_q;
    logic                mem_op;
    logic                is_b;
    logic                is_h;
    logic                misalign;
    logic                go;
    logic [3:0]          mask;
    logic [DATA_W-1:0]   wdata_sh;
    always_comb begin
        mem_op   = bus.in_valid && (bus.in_load || bus.in_store);
        is_b     = bus.in_funct3[1:0] == 2'b00;
        is_h     = bus.in_funct3[1:0] == 2'b01;
        mask     = is_b ? 4'b0001 << bus.in_addr[1:0] : is_h ? 4'b0011 << {bus.in_addr[1], 1'b0} : 4'b1111;
        wdata_sh = is_b ? {24'b0, bus.in_wdata[7:0]} << {bus.in_addr[1:0], 3'b000}
                 : is_h ? {16'b0, bus.in_wdata[15:0]} << {bus.in_addr[1], 4'b0000} : bus.in_wdata;
`ifdef MISALIGN_TRAP_EN
        misalign = is_h ? bus.in_addr[0] : !is_b && bus.in_addr[1:0] != 2'b00;
`else
        misalign = 1'b0;
`endif
        go       = !rst && state == IDLE && mem_op && !misalign;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            mask_q  <= '0;
            be_q    <= '0;
            mbe_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    addr_q  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
                    wdata_q <= wdata_sh;
                    mask_q  <= mask;
                    be_q    <= bus.in_store ? mask : 4'b1111;
                    read_q  <= !bus.in_store;
                    write_q <= bus.in_store;
                    state   <= ACCESS;
                end
                ACCESS: if (bus.dmem_resp) begin
                    // write_q still reflects this access until the edge that clears it
                    if (!write_q) mdr_q <= bus.dmem_rdata;
                    mbe_q   <= mask_q;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    valid_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.stall_o             = go || state == ACCESS;
    assign bus.dmem_read           = read_q;
    assign bus.dmem_write          = write_q;
    assign bus.dmem_addr           = addr_q;
    assign bus.dmem_wdata          = wdata_q;
    assign bus.dmem_byte_enable    = be_q;
    assign bus.mdr_out             = mdr_q;
    assign bus.mem_byte_enable_out = mbe_q;
    assign bus.out_valid           = valid_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.misalign_o          = !rst && state == IDLE && mem_op && misalign;
`endif
endmodule
